// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg -- shared definitions for the oversampling UART receiver.
//   state_t      : receiver FSM states
//   TICK_*       : 16 ticks per bit, majority samples at ticks 7/8/9
//   PARITY_*     : parity_odd input encoding
//   maj3()       : 2-of-3 majority vote
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  localparam int unsigned TICKS_PER_BIT = 16;
  localparam int unsigned TICK_W        = 4;

  localparam logic [TICK_W-1:0] TICK_SAMPLE_A = 4'd7;
  localparam logic [TICK_W-1:0] TICK_SAMPLE_B = 4'd8;
  localparam logic [TICK_W-1:0] TICK_SAMPLE_C = 4'd9;
  localparam logic [TICK_W-1:0] TICK_LAST     = 4'd15;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick -- 1/16-bit tick generator.
//   clk     : clock
//   nrst    : synchronous active-low reset
//   en      : counter runs while high, held at 0 while low
//   restart : realign the counter to 0 (start-edge detection)
//   tick    : one-cycle pulse every CLK_DIV clk cycles
// ---------------------------------------------------------------------------
module uart_baud_tick #(
  parameter int unsigned CLK_DIV = 651
) (
  input  logic clk,
  input  logic nrst,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!nrst || !en || restart) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && !restart && (cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_ovs.sv
// ---------------------------------------------------------------------------
// uart_rx_ovs -- 16x oversampling UART receiver with 2-of-3 bit voting,
// one-word holding register and sticky overrun flag.
//   clk, nrst           : clock, synchronous active-low reset
//   en                  : receiver enable (low aborts any frame in progress)
//   rx                  : asynchronous serial line, idle high
//   parity_odd          : 0 even / 1 odd parity (parity builds only)
//   dout, valid, ready  : received word and valid/ready handshake
//   frame_err           : held frame had a low stop bit
//   parity_err          : held frame had a parity mismatch
//   overrun, clr_ovr    : sticky dropped-frame flag and its clear
// Build option: define UART_RX_OVS_PARITY_EN to receive a parity bit.
// ---------------------------------------------------------------------------
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 651,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 en,
  input  logic                 rx,
  input  logic                 parity_odd,
  output logic [DATA_BITS-1:0] dout,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  input  logic                 clr_ovr
);

  logic              rx_s1, rx_s2, rx_d;
  state_t            state;
  logic [TICK_W-1:0] tick_cnt;
  logic [2:0]        bit_cnt;
  logic              samp_a, samp_b;
  logic [DATA_BITS-1:0] shreg;
  logic              ferr_acc;
  logic              tick, restart, fall, maj, frame_done;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  always_comb begin
    fall       = rx_d & ~rx_s2;
    restart    = en && (state == IDLE) && fall;
    maj        = maj3(samp_a, samp_b, rx_s2);
    frame_done = tick && (state == STOP) && (tick_cnt == TICK_SAMPLE_C) &&
                 (bit_cnt == 3'(STOP_BITS - 1));
  end

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .nrst    (nrst),
    .en      (en),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      samp_a   <= 1'b1;
      samp_b   <= 1'b1;
      shreg    <= '0;
      ferr_acc <= 1'b0;
    end else if (!en) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      if (tick) begin
        tick_cnt <= tick_cnt + 1'b1;
        if (tick_cnt == TICK_SAMPLE_A) samp_a <= rx_s2;
        if (tick_cnt == TICK_SAMPLE_B) samp_b <= rx_s2;
      end
      case (state)
        IDLE: begin
          if (fall) begin
            state    <= START;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            ferr_acc <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            if (tick_cnt == TICK_SAMPLE_C && maj) state <= IDLE;
            else if (tick_cnt == TICK_LAST)       state <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (tick_cnt == TICK_SAMPLE_C)
              shreg <= {maj, shreg[DATA_BITS-1:1]};
            if (tick_cnt == TICK_LAST) begin
              if (bit_cnt == 3'(DATA_BITS - 1)) begin
                bit_cnt <= '0;
`ifdef UART_RX_OVS_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
        end
`ifdef UART_RX_OVS_PARITY_EN
        PARITY: begin
          if (tick && tick_cnt == TICK_LAST) state <= STOP;
        end
`endif
        STOP: begin
          if (tick) begin
            if (tick_cnt == TICK_SAMPLE_C) begin
              if (!maj) ferr_acc <= 1'b1;
              // Last stop bit: leave at its mid-point; WAIT_IDLE reuses
              // tick_cnt as its count of consecutive high ticks.
              if (bit_cnt == 3'(STOP_BITS - 1)) begin
                state    <= (ferr_acc || !maj) ? WAIT_IDLE : IDLE;
                tick_cnt <= '0;
              end
            end else if (tick_cnt == TICK_LAST) begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        WAIT_IDLE: begin
          if (tick) begin
            if (!rx_s2)                       tick_cnt <= '0;
            else if (tick_cnt == TICK_LAST)   state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_RX_OVS_PARITY_EN
  logic perr_acc, perr_q, par_exp;

  assign par_exp    = (^shreg) ^ (parity_odd == PARITY_ODD);
  assign parity_err = perr_q;

  always_ff @(posedge clk) begin
    if (!nrst || state == IDLE) begin
      perr_acc <= 1'b0;
    end else if (en && tick && state == PARITY && tick_cnt == TICK_SAMPLE_C) begin
      perr_acc <= maj ^ par_exp;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      perr_q <= 1'b0;
    end else if (frame_done && !(valid && !ready)) begin
      perr_q <= perr_acc;
    end
  end
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
  assign parity_err        = 1'b0;
`endif

  // A completing frame is dropped only when the held word is still
  // unaccepted; a same-cycle accept frees the slot for the new word.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      dout      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (frame_done) begin
        if (!(valid && !ready)) begin
          dout      <= shreg;
          frame_err <= ferr_acc || !maj;
          valid     <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
      if (frame_done && valid && !ready) overrun <= 1'b1;
      else if (clr_ovr)                   overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_ovs.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_ovs -- directed bench for uart_rx_ovs (CLK_DIV=4, 8N1, 64 clk
// per bit). Honours UART_RX_OVS_PARITY_EN by appending a parity bit.
// ---------------------------------------------------------------------------
module tb_uart_rx_ovs;
  import uart_pkg::*;

  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       en = 1'b1;
  logic       rx = 1'b1;
  logic       parity_odd = 1'b0;
  logic       ready = 1'b1;
  logic       clr_ovr = 1'b0;
  logic [7:0] dout;
  logic       valid, frame_err, parity_err, overrun;

  int checks = 0;
  int errors = 0;
  int vcount = 0;
  int v0;
  logic [7:0] last_dout = '0;
  logic       last_ferr = 1'b0;
  logic       last_perr = 1'b0;

  uart_rx_ovs #(.CLK_DIV(4), .DATA_BITS(8), .STOP_BITS(1)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .en         (en),
    .rx         (rx),
    .parity_odd (parity_odd),
    .dout       (dout),
    .valid      (valid),
    .ready      (ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .clr_ovr    (clr_ovr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) begin
      vcount    = vcount + 1;
      last_dout = dout;
      last_ferr = frame_err;
      last_perr = parity_err;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_flip,
                            input int abort_pos, input logic abort_rst);
    logic [11:0] bits;
    int n;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    n = 9;
`ifdef UART_RX_OVS_PARITY_EN
    bits[n] = (^d) ^ parity_odd ^ par_flip;
    n++;
`else
    if (par_flip) bits[11] = 1'b1;
`endif
    bits[n] = stop_v;
    n++;
    for (int b = 0; b < n; b++) begin
      rx = bits[b];
      if (b == abort_pos) begin
        repeat (BIT_CLKS / 2) @(negedge clk);
        rx = 1'b1;
        if (abort_rst) nrst = 1'b0;
        else           en   = 1'b0;
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        en   = 1'b1;
        break;
      end
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (4) @(negedge clk);
    #1;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_dout", 32'(dout), 32'h00);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_perr", 32'(parity_err), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    @(negedge clk);
    nrst = 1'b1;
    repeat (10) @(negedge clk);

    // Good frame 0xA5, ready=1: one-cycle valid
    v0 = vcount;
    send_frame(8'hA5, 1'b1, 1'b0, -1, 1'b0);
    repeat (20) @(negedge clk);
    #1;
    check("a5_vcycles", 32'(vcount - v0), 32'd1);
    check("a5_dout", 32'(last_dout), 32'hA5);
    check("a5_ferr", 32'(last_ferr), 32'd0);
    check("a5_perr", 32'(last_perr), 32'd0);
    check("a5_valid_dropped", 32'(valid), 32'd0);

    // 20-clk low glitch: false start
    v0 = vcount;
    @(negedge clk);
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    #1;
    check("glitch_no_valid", 32'(vcount - v0), 32'd0);
    check("glitch_idle", 32'(dut.state), 32'(IDLE));

    // 0x3C with low stop bit
    @(negedge clk);
    v0 = vcount;
    send_frame(8'h3C, 1'b0, 1'b0, -1, 1'b0);
    #1;
    check("3c_vcycles", 32'(vcount - v0), 32'd1);
    check("3c_dout", 32'(last_dout), 32'h3C);
    check("3c_ferr", 32'(last_ferr), 32'd1);
    check("3c_wait_idle", 32'(dut.state), 32'(WAIT_IDLE));
    repeat (30) @(negedge clk);
    #1;
    check("3c_still_wait", 32'(dut.state), 32'(WAIT_IDLE));
    repeat (60) @(negedge clk);
    #1;
    check("3c_back_idle", 32'(dut.state), 32'(IDLE));

    // Overrun: ready=0, 0x11 then 0x22
    @(negedge clk);
    ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0, -1, 1'b0);
    repeat (20) @(negedge clk);
    #1;
    check("ovr_first_valid", 32'(valid), 32'd1);
    check("ovr_first_clear", 32'(overrun), 32'd0);
    send_frame(8'h22, 1'b1, 1'b0, -1, 1'b0);
    repeat (20) @(negedge clk);
    #1;
    check("ovr_valid", 32'(valid), 32'd1);
    check("ovr_dout_kept", 32'(dout), 32'h11);
    check("ovr_set", 32'(overrun), 32'd1);
    @(negedge clk);
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    #1;
    check("ovr_cleared", 32'(overrun), 32'd0);
    check("ovr_valid_after_clr", 32'(valid), 32'd1);
    check("ovr_dout_after_clr", 32'(dout), 32'h11);
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    #1;
    check("ovr_accept_drops_valid", 32'(valid), 32'd0);

`ifdef UART_RX_OVS_PARITY_EN
    // Parity: even, 0x07 needs parity bit 1
    @(negedge clk);
    parity_odd = 1'b0;
    send_frame(8'h07, 1'b1, 1'b1, -1, 1'b0);
    repeat (20) @(negedge clk);
    #1;
    check("par_bad_dout", 32'(last_dout), 32'h07);
    check("par_bad_perr", 32'(last_perr), 32'd1);
    send_frame(8'h07, 1'b1, 1'b0, -1, 1'b0);
    repeat (20) @(negedge clk);
    #1;
    check("par_good_perr", 32'(last_perr), 32'd0);
`else
    check("par_tied_low", 32'(parity_err), 32'd0);
`endif

    // Abort mid data bit 4 via nrst, then via en; next frame 0x5A clean
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      v0 = vcount;
      send_frame(8'h00, 1'b1, 1'b0, 5, (k == 0));
      repeat (200) @(negedge clk);
      #1;
      check(k == 0 ? "abort_rst_no_valid" : "abort_en_no_valid", 32'(vcount - v0), 32'd0);
      check(k == 0 ? "abort_rst_idle" : "abort_en_idle", 32'(dut.state), 32'(IDLE));
      @(negedge clk);
      v0 = vcount;
      send_frame(8'h5A, 1'b1, 1'b0, -1, 1'b0);
      repeat (20) @(negedge clk);
      #1;
      check(k == 0 ? "after_rst_vcycles" : "after_en_vcycles", 32'(vcount - v0), 32'd1);
      check(k == 0 ? "after_rst_dout" : "after_en_dout", 32'(last_dout), 32'h5A);
      check(k == 0 ? "after_rst_ferr" : "after_en_ferr", 32'(last_ferr), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
